// File: rtl/mem_stream_ctrl.sv
// rtl/mem_stream_ctrl.sv - loads a stream burst into the register memory, then drains it back out in order
module mem_stream_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_BITS:0]    len,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam int LW = ADDR_BITS + 1;
  localparam logic [ADDR_BITS:0] DEPTH = LW'(1 << ADDR_BITS);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RD_REQ,
    RD_WAIT,
    OUT,
    DONE
  } state_t;

  state_t                state, state_d;
  logic [ADDR_BITS-1:0]  cnt, cnt_d;
  logic [ADDR_BITS:0]    len_q, len_d;
  logic [DATA_WIDTH-1:0] out_data_d;
  logic                  at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      len_q    <= '0;
      out_data <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      len_q    <= len_d;
      out_data <= out_data_d;
    end
  end

  // len_q is one bit wider than cnt so a full 32-word burst ends at cnt=31 without wrapping
  assign at_last = ({1'b0, cnt} == (len_q - LW'(1)));

  assign mem_addr    = cnt;
  assign mem_data_in = in_data;

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    len_d      = len_q;
    out_data_d = out_data;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    mem_wen    = 1'b0;
    busy       = (state != IDLE);
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            len_d   = (len > DEPTH) ? DEPTH : len;
            cnt_d   = '0;
            state_d = LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        mem_wen  = in_valid;
        if (in_valid) begin
          if (at_last) begin
            cnt_d   = '0;
            state_d = RD_REQ;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      RD_REQ: begin
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        out_data_d = mem_data_out;
        state_d    = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        out_last  = at_last;
        if (out_ready) begin
          if (at_last) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt + 1'b1;
            state_d = RD_REQ;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_stream_ctrl.sv
// tb/tb_mem_stream_ctrl.sv - randomized scoreboard bench for mem_stream_ctrl with a 32x8 memory model
module tb_mem_stream_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] len = '0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready = 1'b1;
  logic       busy;
  logic       done;
  logic [4:0] mem_addr;
  logic [7:0] mem_data_in;
  logic       mem_wen;
  logic [7:0] mem_data_out;

  always #5 clk = ~clk;

  mem_stream_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_wen(mem_wen), .mem_data_out(mem_data_out)
  );

  // 32x8 memory with registered read port; data_out reads as 0 on write cycles
  logic [7:0] mem [32];
  logic [7:0] mem_rd = '0;
  assign mem_data_out = mem_rd;
  always @(posedge clk) begin
    if (mem_wen) begin
      mem[mem_addr] <= mem_data_in;
      mem_rd <= '0;
    end else begin
      mem_rd <= mem[mem_addr];
    end
  end

  int total = 0;
  int bad = 0;
  logic [8:0]  exp_out [$];
  logic [12:0] exp_wr [$];
  int exp_done = 0;
  int done_seen = 0;
  int hs_cnt = 0;
  int ready_mode = 0;
  int stall_cnt = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // monitor: all DUT outputs are sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_wen) begin
        if (exp_wr.size() == 0) check("unexpected_write", 1, 0);
        else begin
          logic [12:0] w;
          w = exp_wr.pop_front();
          check("write_addr", int'(mem_addr), int'(w[12:8]));
          check("write_data", int'(mem_data_in), int'(w[7:0]));
        end
      end
      if (prev_stall) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_data", int'(out_data), int'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) check("unexpected_output", 1, 0);
        else begin
          logic [8:0] e;
          e = exp_out.pop_front();
          check("out_data", int'(out_data), int'(e[7:0]));
          check("out_last", int'(out_last), int'(e[8]));
        end
        hs_cnt++;
      end
      if (done) begin
        done_seen++;
        if (prev_done) check("done_width", 2, 1);
      end
      prev_done  = done;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end
  end

  // output ready driver: 0 = always ready, 1 = random, 2 = hold off 5 cycles on word 2
  always @(posedge clk) begin
    #1;
    if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else if (ready_mode == 2 && out_valid && hs_cnt == 2 && stall_cnt < 5) begin
      out_ready = 1'b0;
      stall_cnt++;
    end else out_ready = 1'b1;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, int'(in_ready), 0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_last"}, int'(out_last), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_mem_wen"}, int'(mem_wen), 0);
    check({tag, "_mem_addr"}, int'(mem_addr), 0);
    check({tag, "_out_data"}, int'(out_data), 0);
  endtask

  task automatic start_burst(input int l, input logic [7:0] d [], input bit expect_done);
    int n;
    n = (l > 32) ? 32 : l;
    for (int i = 0; i < n; i++) begin
      exp_wr.push_back({5'(i), d[i]});
      exp_out.push_back({(i == n - 1), d[i]});
    end
    if (expect_done) exp_done++;
    hs_cnt = 0;
    stall_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1;
    len = 6'(l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int n, input bit gaps, input logic [7:0] d []);
    for (int i = 0; i < n; i++) begin
      int tries;
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      in_data = d[i];
      tries = 0;
      @(negedge clk);
      while (!in_ready && tries < 1000) begin @(negedge clk); tries++; end
      if (tries >= 1000) check("in_ready_timeout", 0, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data = 8'($urandom);
  endtask

  task automatic wait_idle();
    int tries;
    tries = 0;
    @(negedge clk);
    while (busy && tries < 3000) begin @(negedge clk); tries++; end
    if (tries >= 3000) check("idle_timeout", 0, 1);
    check("drained_outputs", exp_out.size(), 0);
    check("drained_writes", exp_wr.size(), 0);
    check("done_count", done_seen, exp_done);
  endtask

  task automatic run_burst(input int l, input bit gaps, input logic [7:0] d []);
    int n;
    n = (l > 32) ? 32 : l;
    start_burst(l, d, 1'b1);
    if (n > 0) feed(n, gaps, d);
    wait_idle();
  endtask

  initial begin
    logic [7:0] d [];
    d = new[40];
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    #3 rst_n = 1'b1;

    foreach (d[i]) d[i] = 8'($urandom);
    run_burst(3, 1'b0, d);

    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
    run_burst(4, 1'b0, d);

    ready_mode = 2;
    foreach (d[i]) d[i] = 8'($urandom);
    run_burst(6, 1'b1, d);
    ready_mode = 0;

    foreach (d[i]) d[i] = 8'(i) ^ 8'hA5;
    run_burst(32, 1'b0, d);

    foreach (d[i]) d[i] = 8'($urandom);
    run_burst(40, 1'b1, d);

    run_burst(0, 1'b0, d);

    // abort during the second output word: no done, remaining words never appear
    foreach (d[i]) d[i] = 8'($urandom);
    start_burst(4, d, 1'b0);
    feed(4, 1'b0, d);
    begin
      int tries;
      tries = 0;
      @(negedge clk);
      while (!(out_valid && hs_cnt == 1) && tries < 200) begin @(negedge clk); tries++; end
      if (tries >= 200) check("drain_timeout", 0, 1);
    end
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    exp_out.delete();
    exp_wr.delete();
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_done", done_seen, exp_done);

    foreach (d[i]) d[i] = 8'($urandom);
    run_burst(2, 1'b0, d);

    ready_mode = 1;
    for (int k = 0; k < 6; k++) begin
      foreach (d[i]) d[i] = 8'($urandom);
      run_burst($urandom_range(0, 40), 1'($urandom_range(0, 1)), d);
    end
    ready_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
